// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: instruction field
// codes, ALU control codes, the controller state encoding and the datapath
// mux-select encodings. Imported by mips_multicycle_control.
package mips_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct codes
    localparam logic [5:0] FUNCT_JR = 6'h08;

    // ALU control codes (zero-extended to the alu_op port width)
    localparam logic [3:0] ALU_NONE   = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0001;
    localparam logic [3:0] ALU_SW     = 4'b0010;
    localparam logic [3:0] ALU_BRANCH = 4'b0011;
    localparam logic [3:0] ALU_ADDI   = 4'b0100;
    localparam logic [3:0] ALU_ORI    = 4'b0101;
    localparam logic [3:0] ALU_LUI    = 4'b0110;
    localparam logic [3:0] ALU_ANDI   = 4'b1101;
    localparam logic [3:0] ALU_RTYPE  = 4'b1111;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JR       = 4'd11
    } state_t;

    // pc_source selects
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    // reg_dst selects
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // mem_to_reg selects
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // alu_src_a / alu_src_b selects
    localparam logic       ALUA_PC      = 1'b0;
    localparam logic       ALUA_RS      = 1'b1;
    localparam logic [1:0] ALUB_RT      = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    // ALU code for the immediate-ALU instructions executed in EXEC_I
    function automatic logic [3:0] imm_alu_code(input logic [5:0] op);
        case (op)
            OP_ADDI: return ALU_ADDI;
            OP_ORI:  return ALU_ORI;
            OP_ANDI: return ALU_ANDI;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   clear : synchronous clear to zero (has priority over inc)
//   inc   : add one, unless already all-ones
//   count : current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM. Sequences each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the datapath strobes.
// Memory states wait on mem_ready; ir_write, pc_write, retire and the state
// advance in those states are qualified by mem_ready.
//   clk, reset           : clock and synchronous active-high reset
//   op, funct            : fields of the instruction register
//   mem_ready            : shared memory completes the access this cycle
//   pc_write*, pc_source : PC update control
//   i_or_d, mem_read/write, ir_write : memory interface control
//   reg_dst, mem_to_reg, reg_write   : register file write control
//   alu_src_a/b, alu_op  : ALU operand and operation control
//   illegal              : pulse on an unsupported instruction in DECODE
//   retire, instr_count  : completion pulse and saturating retire counter
//   state_dbg            : current state encoding
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,  // must be >= 4
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_eq,
    output logic               pc_write_ne,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic               retire,
    output logic [CNT_W-1:0]   instr_count,
    output logic [3:0]         state_dbg
);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_reg_dst;       // write-back destination chosen at dispatch
    logic [1:0] w_reg_dst_next;
    logic [3:0] w_alu_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_reg_dst <= REGDST_RT;
        end else begin
            r_state   <= w_state_next;
            r_reg_dst <= w_reg_dst_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_reg_dst_next = r_reg_dst;
        w_alu_code     = ALU_NONE;
        pc_write       = 1'b0;
        pc_write_eq    = 1'b0;
        pc_write_ne    = 1'b0;
        pc_source      = PCSRC_ALU;
        i_or_d         = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        reg_dst        = REGDST_RT;
        mem_to_reg     = M2R_ALUOUT;
        reg_write      = 1'b0;
        alu_src_a      = ALUA_PC;
        alu_src_b      = ALUB_RT;
        illegal        = 1'b0;
        retire         = 1'b0;

        // Outputs stay quiet while reset is held, whatever state we are in.
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = ALUB_FOUR;
                    w_alu_code = ALU_ADD;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        w_state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Speculatively compute the branch target into ALUOut.
                    alu_src_b  = ALUB_IMM_SH2;
                    w_alu_code = ALU_ADD;
                    case (op)
                        OP_RTYPE: begin
                            if (funct == FUNCT_JR) begin
                                w_state_next = S_JR;
                            end else begin
                                w_state_next   = S_EXEC_R;
                                w_reg_dst_next = REGDST_RD;
                            end
                        end
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                            w_state_next   = S_EXEC_I;
                            w_reg_dst_next = REGDST_RT;
                        end
                        OP_LW, OP_SW:   w_state_next = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
                        OP_J, OP_JAL:   w_state_next = S_JUMP;
                        default: begin
                            illegal      = 1'b1;
                            w_state_next = S_FETCH;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a    = ALUA_RS;
                    alu_src_b    = ALUB_RT;
                    w_alu_code   = ALU_RTYPE;
                    w_state_next = S_WB_ALU;
                end
                S_EXEC_I: begin
                    alu_src_a    = ALUA_RS;
                    alu_src_b    = ALUB_IMM;
                    w_alu_code   = imm_alu_code(op);
                    w_state_next = S_WB_ALU;
                end
                S_WB_ALU: begin
                    reg_write    = 1'b1;
                    reg_dst      = r_reg_dst;
                    mem_to_reg   = M2R_ALUOUT;
                    retire       = 1'b1;
                    w_state_next = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a    = ALUA_RS;
                    alu_src_b    = ALUB_IMM;
                    w_alu_code   = ALU_ADD;
                    w_state_next = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        w_state_next = S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    reg_write    = 1'b1;
                    reg_dst      = REGDST_RT;
                    mem_to_reg   = M2R_MDR;
                    retire       = 1'b1;
                    w_state_next = S_FETCH;
                end
                S_MEM_WR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        retire       = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    alu_src_a    = ALUA_RS;
                    alu_src_b    = ALUB_RT;
                    w_alu_code   = ALU_BRANCH;
                    pc_source    = PCSRC_ALUOUT;
                    pc_write_eq  = (op == OP_BEQ);
                    pc_write_ne  = (op == OP_BNE);
                    retire       = 1'b1;
                    w_state_next = S_FETCH;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                    if (op == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = REGDST_RA;
                        mem_to_reg = M2R_PC;
                    end
                    retire       = 1'b1;
                    w_state_next = S_FETCH;
                end
                S_JR: begin
                    pc_write     = 1'b1;
                    pc_source    = PCSRC_RS;
                    retire       = 1'b1;
                    w_state_next = S_FETCH;
                end
                default: begin
                    w_state_next = S_FETCH;
                end
            endcase
        end
    end

    assign alu_op    = ALUOP_W'(w_alu_code);
    assign state_dbg = r_state;

    sat_counter #(
        .W(CNT_W)
    ) u_instr_count (
        .clk  (clk),
        .clear(reset),
        .inc  (retire),
        .count(instr_count)
    );

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multi-cycle successor to the single-cycle MIPS decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives per-state datapath strobes. It supports a shared instruction/data memory with a ready handshake (wait states) and executes J, JAL and JR (decoded from opcode plus funct). It sits between the instruction register and the multi-cycle datapath, and exposes a retired-instruction counter for CPI measurement.

Parameters:
ALUOP_W, 4, width of alu_op; must be >= 4, upper bits zero-filled.
CNT_W, 32, width of the retired-instruction counter; saturates at all-ones.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  opcode field of the instruction register
funct  in  6  funct field of the instruction register
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_eq  out  1  PC load if ALU zero (BEQ)
pc_write_ne  out  1  PC load if ALU not zero (BNE)
pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=rs (JR)
i_or_d  out  1  0=PC address, 1=ALUOut address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_dst  out  2  0=rt, 1=rd, 2=$31
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC (link)
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
alu_op  out  ALUOP_W  ALU control code
illegal  out  1  one-cycle pulse: unsupported opcode/funct in DECODE
retire  out  1  one-cycle pulse when an instruction completes
instr_count  out  CNT_W  retired instructions, saturating
state_dbg  out  4  current state encoding

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, WB_ALU, BRANCH, JUMP, JR.
- Reset:
  - Synchronous, active-high. State goes to FETCH and instr_count goes to 0.
  - While reset is high, all 1-bit strobes and illegal/retire are 0. Mux selects and alu_op are 0.
  - Reset asserted mid-instruction (including during a memory wait) aborts the instruction with no retire.
- Strobe rules:
  - Strobes default to 0 in every state not listed below.
  - mem_read/mem_write are held high until mem_ready. ir_write, pc_write and the state advance qualify on mem_ready (Mealy in memory states only).
- FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_source=0, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut). Dispatch:
  - op=0 and funct=0x08 -> JR.
  - op=0 (other funct) -> EXEC_R.
  - 0x08/0x0C/0x0D/0x0F -> EXEC_I.
  - 0x23/0x2B -> MEM_ADDR.
  - 0x04/0x05 -> BRANCH.
  - 0x02/0x03 -> JUMP.
  - Anything else -> illegal=1, back to FETCH, no retire.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=R_TYPE, then WB_ALU with reg_dst=1.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op from the per-opcode code, then WB_ALU with reg_dst=0.
- WB_ALU: reg_write=1, mem_to_reg=0, retire=1, then FETCH. reg_dst is registered from the dispatch path.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Go to MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: i_or_d=1, mem_read=1. Wait on mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1, then FETCH.
- MEM_WR: i_or_d=1, mem_write=1. Wait on mem_ready, then retire=1 and FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=BRANCH, pc_source=1. pc_write_eq=1 (0x04) or pc_write_ne=1 (0x05). retire=1, then FETCH.
- JUMP: pc_write=1, pc_source=2, retire=1, then FETCH. For JAL also reg_write=1, reg_dst=2, mem_to_reg=2.
- JR: pc_write=1, pc_source=3, retire=1, then FETCH.
- ALU codes: R_TYPE=1111, ADDI=0100, ORI=0101, ANDI=1101, LUI=0110, ADD(LW/addr)=0001, SW=0010, BRANCH=0011. Codes are zero-extended to ALUOP_W.
- Zero-wait cycle counts: R/I-ALU 4, LW 5, SW 4, BEQ/BNE/J/JAL/JR 3. Each mem_ready=0 cycle adds one.
- instr_count increments on each retire and holds at all-ones.

Decomposition:
- Package mips_ctrl_pkg holds: opcode/funct localparams, the ALU code constants, the state enum (4-bit), and the pc_source/reg_dst/mem_to_reg select encodings.
- One sub-module, sat_counter (parameter W, ports: inc, clear), implements instr_count.
- The FSM and output decode stay in mips_multicycle_control.

Test Plan:
- Reset for 2 cycles, then release with mem_ready=1 -> state_dbg=FETCH, instr_count=0. First cycle after release: mem_read=1, ir_write=1, pc_write=1.
- op=0, funct=0x20, mem_ready=1 -> exactly 4 cycles. WB_ALU shows reg_write=1, reg_dst=1, alu_op=1111 in EXEC_R. retire pulses once; instr_count=1.
- LW (op=0x23) with mem_ready held 0 for 3 cycles in MEM_RD -> mem_read stays 1 for all 3 waits plus the ready cycle. Total 8 cycles; MEM_WB shows mem_to_reg=1.
- JAL (op=0x03) -> JUMP cycle shows pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2. JR (op=0, funct=0x08) -> pc_source=3, no reg_write.
- op=0x3F -> illegal pulses for 1 cycle in DECODE, next state FETCH, instr_count unchanged.
- Reset asserted during a MEM_WR wait -> the next cycle shows FETCH with mem_write=0 and no retire. With CNT_W=2 and 5 retires, instr_count saturates at 3.
